sqwave_meter: RTL and testbench

Measures the square wave produced by the programmable square-wave generator, `sqwaveGen`, and sits directly downstream of it, on its `clk_out`. It counts, in `clk` cycles, the high phase and low phase of each full period. It reports both lengths with a one-cycle valid strobe and flags whether they match the expected high/low settings. It also flags counter overflow and a stuck (edge-less) input. Use it as an on-chip self-check of the generator and as a duty-cycle monitor.

---
 rtl/sqwave_pkg.sv | 17 +
 rtl/sqwave_edge_det.sv | 31 +++
 rtl/sqwave_meter.sv | 177 +++++++++++++++++
 tb/tb_sqwave_meter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sqwave_pkg.sv
// sqwave_pkg: definitions shared by the square-wave meter files.
//   CNT_W_DEF : default width of the phase counters and length outputs
//   SET_W     : width of the expected high/low settings (matches the
//               generator's rise/fall setting fields)
//   state_t   : measurement FSM state encoding
package sqwave_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int SET_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/sqwave_edge_det.sv
// sqwave_edge_det: two-flop sampler of the measured wave with edge outputs.
//   clk     : system clock
//   rst     : asynchronous active-low reset
//   wave_in : square wave under test (synchronous to clk)
//   rise    : wave_q high while wave_d still low (one cycle per rising edge)
//   fall    : wave_q low while wave_d still high (one cycle per falling edge)
module sqwave_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic wave_in,
  output logic rise,
  output logic fall
);

  logic wave_q;
  logic wave_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wave_q <= 1'b0;
      wave_d <= 1'b0;
    end else begin
      wave_q <= wave_in;
      wave_d <= wave_q;
    end
  end

  assign rise = wave_q & ~wave_d;
  assign fall = ~wave_q & wave_d;

endmodule

// File: rtl/sqwave_meter.sv
// sqwave_meter: measures high and low phase lengths (in clk cycles) of a
// square wave and checks them against expected settings.
//   clk, rst   : system clock, asynchronous active-low reset
//   clr        : synchronous restart of the measurement (back to IDLE)
//   wave_in    : square wave under test
//   exp_high   : expected high length, exp_low : expected low length
//   high_len   : last completed high-phase length
//   low_len    : last completed low-phase length
//   period_len : high_len + low_len, one bit wider so it never truncates
//   meas_valid : one-cycle strobe; lengths, match and ovf change only in
//                the cycle meas_valid is high and hold otherwise. There is
//                no back-pressure: every completed period produces a strobe.
//   match      : reported lengths equal the expected settings
//   ovf        : a phase counter saturated during the reported period
//   stuck      : current phase counter is pinned at all-ones (level)
//   dbg_state  : current FSM state
module sqwave_meter
  import sqwave_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wave_in,
  input  logic [SET_W-1:0] exp_high,
  input  logic [SET_W-1:0] exp_low,
  output logic [CNT_W-1:0] high_len,
  output logic [CNT_W-1:0] low_len,
  output logic [CNT_W:0]   period_len,
  output logic             meas_valid,
  output logic             match,
  output logic             ovf,
  output logic             stuck,
  output logic [1:0]       dbg_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic rise;
  logic fall;

  sqwave_edge_det u_edge_det (
    .clk     (clk),
    .rst     (rst),
    .wave_in (wave_in),
    .rise    (rise),
    .fall    (fall)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [CNT_W-1:0] high_len_q, high_len_d;
  logic [CNT_W-1:0] low_len_q, low_len_d;
  logic [CNT_W:0]   period_len_q, period_len_d;
  logic             meas_valid_q, meas_valid_d;
  logic             match_q, match_d;
  logic             ovf_q, ovf_d;

  logic [CNT_W-1:0] exp_high_ext;
  logic [CNT_W-1:0] exp_low_ext;
  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_sat;

  // Zero-extend the 4-bit settings to counter width (CNT_W >= SET_W).
  always_comb begin
    exp_high_ext              = '0;
    exp_low_ext               = '0;
    exp_high_ext[SET_W-1:0]   = exp_high;
    exp_low_ext[SET_W-1:0]    = exp_low;
  end

  // Saturating increment; an attempt to count past all-ones is remembered
  // so the report for this period can flag it.
  assign cnt_sat = (cnt_q == CNT_MAX);
  assign cnt_inc = cnt_sat ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hi_cap_d     = hi_cap_q;
    ovf_pend_d   = ovf_pend_q;
    high_len_d   = high_len_q;
    low_len_d    = low_len_q;
    period_len_d = period_len_q;
    meas_valid_d = 1'b0;
    match_d      = match_q;
    ovf_d        = ovf_q;

    if (clr) begin
      // Restart wins over any edge; reported outputs keep their values.
      state_d    = ST_IDLE;
      cnt_d      = '0;
      hi_cap_d   = '0;
      ovf_pend_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A phase already in progress is ignored; start on a clean rise.
          if (rise) begin
            state_d = ST_HIGH;
            cnt_d   = CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (fall) begin
            hi_cap_d = cnt_q;
            cnt_d    = CNT_ONE;
            state_d  = ST_LOW;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_sat) ovf_pend_d = 1'b1;
          end
        end
        ST_LOW: begin
          if (rise) begin
            high_len_d   = hi_cap_q;
            low_len_d    = cnt_q;
            period_len_d = {1'b0, hi_cap_q} + {1'b0, cnt_q};
            match_d      = (hi_cap_q == exp_high_ext) && (cnt_q == exp_low_ext);
            ovf_d        = ovf_pend_q;
            ovf_pend_d   = 1'b0;
            meas_valid_d = 1'b1;
            cnt_d        = CNT_ONE;
            state_d      = ST_HIGH;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_sat) ovf_pend_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      hi_cap_q     <= '0;
      ovf_pend_q   <= 1'b0;
      high_len_q   <= '0;
      low_len_q    <= '0;
      period_len_q <= '0;
      meas_valid_q <= 1'b0;
      match_q      <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hi_cap_q     <= hi_cap_d;
      ovf_pend_q   <= ovf_pend_d;
      high_len_q   <= high_len_d;
      low_len_q    <= low_len_d;
      period_len_q <= period_len_d;
      meas_valid_q <= meas_valid_d;
      match_q      <= match_d;
      ovf_q        <= ovf_d;
    end
  end

  assign high_len   = high_len_q;
  assign low_len    = low_len_q;
  assign period_len = period_len_q;
  assign meas_valid = meas_valid_q;
  assign match      = match_q;
  assign ovf        = ovf_q;
  assign stuck      = ((state_q == ST_HIGH) || (state_q == ST_LOW)) && cnt_sat;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sqwave_meter.sv
// tb_sqwave_meter: directed test of sqwave_meter with a 4-bit counter so
// saturation is reachable in a short run.
module tb_sqwave_meter;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       wave_in;
  logic [3:0] exp_high;
  logic [3:0] exp_low;
  logic [3:0] high_len;
  logic [3:0] low_len;
  logic [4:0] period_len;
  logic       meas_valid;
  logic       match;
  logic       ovf;
  logic       stuck;
  logic [1:0] dbg_state;

  int n_checks;
  int n_fail;
  int cyc_n;
  int pulse_cnt;
  int last_cyc;
  int gap;
  int base;

  sqwave_meter #(.CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .wave_in    (wave_in),
    .exp_high   (exp_high),
    .exp_low    (exp_low),
    .high_len   (high_len),
    .low_len    (low_len),
    .period_len (period_len),
    .meas_valid (meas_valid),
    .match      (match),
    .ovf        (ovf),
    .stuck      (stuck),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Pulse monitor: counts strobes and the spacing between consecutive ones.
  always @(negedge clk) begin
    if (meas_valid) begin
      pulse_cnt = pulse_cnt + 1;
      gap       = cyc_n - last_cyc;
      last_cyc  = cyc_n;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Driver tasks: called at posedge+1, return at posedge+1.
  task automatic hold(input logic v, input int n);
    wave_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic period(input int h, input int l);
    hold(1'b1, h);
    hold(1'b0, l);
  endtask

  task automatic check_report(input string tag, input int h, input int l, input int m);
    check({tag, "_high"},   32'(high_len),   h);
    check({tag, "_low"},    32'(low_len),    l);
    check({tag, "_period"}, 32'(period_len), h + l);
    check({tag, "_match"},  32'(match),      m);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cyc_n     = 0;
    pulse_cnt = 0;
    last_cyc  = 0;
    gap       = 0;
    clr       = 1'b0;
    wave_in   = 1'b0;
    exp_high  = 4'd3;
    exp_low   = 4'd4;
    rst       = 1'b1;
    #1 rst = 1'b0;
    #2;
    check("rst_high",   32'(high_len),   0);
    check("rst_low",    32'(low_len),    0);
    check("rst_period", 32'(period_len), 0);
    check("rst_valid",  32'(meas_valid), 0);
    check("rst_match",  32'(match),      0);
    check("rst_ovf",    32'(ovf),        0);
    check("rst_stuck",  32'(stuck),      0);
    check("rst_state",  32'(dbg_state),  0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    hold(1'b0, 3);

    // Basic 3/4 periods
    base = pulse_cnt;
    repeat (5) period(3, 4);
    check("basic_pulses", 32'(pulse_cnt - base), 4);
    check("basic_gap",    32'(gap), 7);
    check_report("basic", 3, 4, 1);
    check("basic_ovf",    32'(ovf), 0);
    check("basic_valid_low", 32'(meas_valid), 0);

    // Mismatch then setting change
    period(5, 4);
    period(5, 4);
    check_report("mism", 5, 4, 0);
    exp_high = 4'd5;
    period(5, 4);
    check_report("fixed", 5, 4, 1);
    check("fixed_gap", 32'(gap), 9);

    // Reset released while wave high; then 1/1 periods
    rst     = 1'b0;
    wave_in = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    base = pulse_cnt;
    hold(1'b1, 4);
    hold(1'b0, 3);
    check("partial_pulses", 32'(pulse_cnt - base), 0);
    exp_high = 4'd1;
    exp_low  = 4'd1;
    repeat (6) period(1, 1);
    @(negedge clk);
    #1;
    check("fast_pulses", 32'(pulse_cnt - base), 6);
    check("fast_gap",    32'(gap), 2);
    check_report("fast", 1, 1, 1);
    @(posedge clk);
    #1;

    // Saturation and stuck
    exp_high = 4'd15;
    exp_low  = 4'd2;
    hold(1'b0, 2);
    hold(1'b1, 15);
    check("stuck_early", 32'(stuck), 0);
    hold(1'b1, 1);
    check("stuck_set",   32'(stuck), 1);
    hold(1'b1, 4);
    check("stuck_hold",  32'(stuck), 1);
    hold(1'b0, 1);
    check("stuck_pre_fall", 32'(stuck), 1);
    hold(1'b0, 1);
    check("stuck_clear", 32'(stuck), 0);
    hold(1'b1, 2);
    check("sat_valid", 32'(meas_valid), 1);
    check_report("sat", 15, 2, 1);
    check("sat_ovf", 32'(ovf), 1);
    hold(1'b1, 1);
    hold(1'b0, 2);
    hold(1'b1, 2);
    check("post_sat_valid", 32'(meas_valid), 1);
    check_report("post_sat", 3, 2, 0);
    check("post_sat_ovf", 32'(ovf), 0);

    // clr in the same cycle a rise would report
    exp_high = 4'd3;
    exp_low  = 4'd2;
    hold(1'b1, 1);
    hold(1'b0, 2);
    hold(1'b1, 1);
    base = pulse_cnt;
    clr = 1'b1;
    hold(1'b1, 1);
    clr = 1'b0;
    check("clr_valid", 32'(meas_valid), 0);
    check("clr_state", 32'(dbg_state),  0);
    check_report("clr_hold", 3, 2, 0);
    exp_high = 4'd2;
    exp_low  = 4'd3;
    hold(1'b1, 1);
    hold(1'b0, 2);
    period(2, 3);
    hold(1'b1, 2);
    @(negedge clk);
    #1;
    check("clr_pulses", 32'(pulse_cnt - base), 1);
    check_report("after_clr", 2, 3, 1);
    @(posedge clk);
    #1;
    check("valid_one_cycle", 32'(meas_valid), 0);

    // Reset during a low phase
    hold(1'b0, 2);
    rst = 1'b0;
    #1;
    check("mid_rst_high",   32'(high_len),   0);
    check("mid_rst_low",    32'(low_len),    0);
    check("mid_rst_period", 32'(period_len), 0);
    check("mid_rst_match",  32'(match),      0);
    check("mid_rst_ovf",    32'(ovf),        0);
    check("mid_rst_valid",  32'(meas_valid), 0);
    check("mid_rst_state",  32'(dbg_state),  0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    base = pulse_cnt;
    exp_high = 4'd2;
    exp_low  = 4'd2;
    hold(1'b0, 2);
    period(2, 2);
    check("rerst_no_report", 32'(high_len), 0);
    hold(1'b1, 2);
    @(negedge clk);
    #1;
    check("rerst_pulses", 32'(pulse_cnt - base), 1);
    check_report("rerst", 2, 2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
